shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
- Parametrised successor to the team's 8-bit parallel-load register.
- Single W-bit register with hold, parallel load, logical shift and rotate modes, plus serial in and serial out.
- Built-in serialiser FSM: one start pulse loads a word and streams it out on so over W cycles with busy/done status.
- Used as the general storage/serialisation element feeding serial links and bit-level datapaths.

Parameters:
- W, 8, register width in bits; legal range W >= 2.
- MSB_FIRST, 1, serialiser direction: 1 = shift left, so = do[W-1]; 0 = shift right, so = do[0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  3  operation select, sampled at posedge, ignored while busy
- di  in  W  parallel data in
- si  in  1  serial data in (fill bit for shifts)
- start  in  1  serialiser start; one-cycle pulse, sampled in IDLE only
- do  out  W  register contents
- so  out  1  serial out; combinational from do per MSB_FIRST
- busy  out  1  serialiser active
- done  out  1  one-cycle pulse when serialisation completes

Behaviour:
- Reset (rst_n low, asynchronous): do=0, busy=0, done=0, state=IDLE, bit counter=0. so therefore reads 0.
- Reset asserted mid-serialisation aborts immediately. No done pulse is generated.
- FSM states and transitions:
  - IDLE: start=1 -> LOAD action then SHIFT. Otherwise the mode operation applies.
  - SHIFT: one directional shift per cycle while cnt < W-1. At cnt == W-1 -> IDLE.
- Mode operations in IDLE with start=0 (registered, 1-cycle latency):
  - 000 HOLD
  - 001 LOAD: do <= di
  - 010 SHL: do <= {do[W-2:0], si}
  - 011 SHR: do <= {si, do[W-1:1]}
  - 100 ROTL: do <= {do[W-2:0], do[W-1]}
  - 101 ROTR: do <= {do[0], do[W-1:1]}
  - 110 / 111: reserved, behave as HOLD
- Serialiser timing (edge T0 = edge where start is sampled in IDLE):
  - T0: do <= di, busy <= 1, cnt <= 0.
  - T1..T(W-1): shift in MSB_FIRST direction with si fill; cnt increments.
  - T(W): busy <= 0, done <= 1 for exactly one cycle, no shift, state IDLE. do retains the residue.
  - busy is high for exactly W cycles. so presents bit W-1..0 (MSB_FIRST=1) or 0..W-1 in those cycles.
- Simultaneous start and a non-HOLD mode in IDLE: start wins; mode is ignored.
- start or mode changes while busy: ignored. No queueing, no restart.
- start in the same cycle done is high: accepted, since state is IDLE. Back-to-back words leave a 1-cycle gap on busy.
- Counter width is clog2(W). Counter wraps only via explicit clear at T0.

Optional Feature:
- Macro SHIFT_REG_UNIV_PARITY_EN.
- When defined:
  - extra output parity (1 bit), registered. Reset 0.
  - Updated at T0 of a serialisation to the even parity of di (^di). Held otherwise.
  - done cycle is extended: busy stays high one extra cycle (W+1 total) with so = parity. done follows one cycle later.
- When undefined: no parity port, W-cycle serialisation exactly as above.

Decomposition:
- Shared package shift_reg_pkg holds:
  - mode encodings as constants: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR
  - FSM state encodings: ST_IDLE, ST_SHIFT
- One sub-module: bit_cnt, a clog2(W)-bit up-counter with synchronous clear/enable and a terminal-count flag at W-1.
- Everything else stays in shift_reg_univ.

Test Plan:
- Reset and load (W=8): rst_n low with di=8'hAF -> do=00, busy=0. Release, mode=001 -> do=AF one edge later. mode=000 for 3 cycles -> do stays AF.
- Shifts and rotates: do=AF, mode=010 si=1 -> 5F. mode=011 si=0 -> 2F. mode=100 -> 5E. mode=101 -> 2F. mode=110 -> 2F unchanged.
- Serialise MSB_FIRST=1, di=8'hA5, start pulse:
  - busy high exactly 8 cycles; so sequence 1,0,1,0,0,1,0,1.
  - done high for 1 cycle at busy fall; mode=001 asserted during busy has no effect.
- Serialise MSB_FIRST=0, di=8'h01: so sequence 1,0,0,0,0,0,0,0; start re-pulsed mid-busy is ignored.
- Reset mid-stream: rst_n low at cycle 4 of busy -> do=00, busy=0 asynchronously, no done pulse. A new start after release streams normally.
- With SHIFT_REG_UNIV_PARITY_EN, di=8'h07: busy 9 cycles, final so bit = 1, parity=1, then done pulse.

Source files
------------

// File: rtl/shift_reg_pkg.sv
//------------------------------------------------------------------------------
// Module   : shift_reg_pkg
// Brief    : Mode and serialiser state encodings shared by shift_reg_univ.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;

  // ST_PARITY is only reachable when the parity trailer is built in.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_reg_univ_bit_cnt.sv
//------------------------------------------------------------------------------
// Module   : bit_cnt
// Brief    : clog2(W)-bit up-counter, sync clear/enable, terminal flag at W-1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_cnt #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] c_last = CW'(W - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/shift_reg_univ.sv
//------------------------------------------------------------------------------
// Module   : shift_reg_univ
// Brief    : W-bit universal shift register with built-in start/busy/done
//            serialiser. Define SHIFT_REG_UNIV_PARITY_EN for a parity trailer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   i_mode,
  input  logic [W-1:0] i_di,
  input  logic         i_si,
  input  logic         i_start,
  output logic [W-1:0] o_do,
  output logic         o_so,
  output logic         o_busy,
`ifdef SHIFT_REG_UNIV_PARITY_EN
  output logic         o_parity,
`endif
  output logic         o_done
);

  state_t       r_state;
  logic [W-1:0] r_do;
  logic         r_busy;
  logic         r_done;

  logic         w_start_ok;
  logic         w_shift_en;
  logic         w_tc;
  logic [W-1:0] w_ser_next;
  logic [W-1:0] w_mode_next;
  logic         w_so_data;

  assign w_start_ok = (r_state == ST_IDLE) && i_start;
  assign w_shift_en = (r_state == ST_SHIFT) && !w_tc;

  bit_cnt #(.W(W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_en  (w_shift_en),
    .o_tc  (w_tc)
  );

  assign w_ser_next = MSB_FIRST ? {r_do[W-2:0], i_si} : {i_si, r_do[W-1:1]};

  always_comb begin
    w_mode_next = r_do;
    case (i_mode)
      MODE_LOAD: w_mode_next = i_di;
      MODE_SHL:  w_mode_next = {r_do[W-2:0], i_si};
      MODE_SHR:  w_mode_next = {i_si, r_do[W-1:1]};
      MODE_ROTL: w_mode_next = {r_do[W-2:0], r_do[W-1]};
      MODE_ROTR: w_mode_next = {r_do[0], r_do[W-1:1]};
      default:   w_mode_next = r_do;
    endcase
  end

  // Start outranks any mode in IDLE; the last SHIFT cycle does not shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_do    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_do    <= i_di;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_do <= w_mode_next;
          end
        end
        ST_SHIFT: begin
          if (w_tc) begin
`ifdef SHIFT_REG_UNIV_PARITY_EN
            r_state <= ST_PARITY;
`else
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
`endif
          end else begin
            r_do <= w_ser_next;
          end
        end
        ST_PARITY: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_so_data = MSB_FIRST ? r_do[W-1] : r_do[0];

`ifdef SHIFT_REG_UNIV_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_start_ok) begin
      r_parity <= ^i_di;
    end
  end

  assign o_parity = r_parity;
  assign o_so     = (r_state == ST_PARITY) ? r_parity : w_so_data;
`else
  assign o_so     = w_so_data;
`endif

  assign o_do   = r_do;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
//------------------------------------------------------------------------------
// Module   : tb_shift_reg_univ
// Brief    : Directed bench for shift_reg_univ, MSB-first and LSB-first
//            instances side by side. Honours SHIFT_REG_UNIV_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_reg_univ;

  localparam int W = 8;
`ifdef SHIFT_REG_UNIV_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   r_mode;
  logic [W-1:0] r_di;
  logic         r_si;
  logic         r_start;

  logic [W-1:0] w_do_m, w_do_l;
  logic         w_so_m, w_so_l;
  logic         w_busy_m, w_busy_l;
  logic         w_done_m, w_done_l;
`ifdef SHIFT_REG_UNIV_PARITY_EN
  logic         w_par_m, w_par_l;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_reg_univ #(.W(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_mode  (r_mode),
    .i_di    (r_di),
    .i_si    (r_si),
    .i_start (r_start),
    .o_do    (w_do_m),
    .o_so    (w_so_m),
    .o_busy  (w_busy_m),
`ifdef SHIFT_REG_UNIV_PARITY_EN
    .o_parity(w_par_m),
`endif
    .o_done  (w_done_m)
  );

  shift_reg_univ #(.W(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_mode  (r_mode),
    .i_di    (r_di),
    .i_si    (r_si),
    .i_start (r_start),
    .o_do    (w_do_l),
    .o_so    (w_so_l),
    .o_busy  (w_busy_l),
`ifdef SHIFT_REG_UNIV_PARITY_EN
    .o_parity(w_par_l),
`endif
    .o_done  (w_done_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams d through both instances; at cycle poke_k it pulses start and
  // forces a LOAD of ~d, both of which must be ignored while busy.
  task automatic ser(input logic [W-1:0] d, input int poke_k, input logic [2:0] m,
                     input string tag);
    r_di    = d;
    r_mode  = m;
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      chk({tag, " busy"}, {w_busy_m, w_busy_l}, 2'b11);
      chk({tag, " done"}, {w_done_m, w_done_l}, 2'b00);
      if (k < W) begin
        chk({tag, " so_msb"}, w_so_m, d[W-1-k]);
        chk({tag, " so_lsb"}, w_so_l, d[k]);
      end else begin
        chk({tag, " so_par"}, {w_so_m, w_so_l}, {2{^d}});
      end
      if (k == poke_k) begin
        r_start = 1'b1;
        r_mode  = 3'b001;
        r_di    = ~d;
      end else begin
        r_start = 1'b0;
      end
      tick();
    end
    r_start = 1'b0;
    chk({tag, " busy_end"}, {w_busy_m, w_busy_l}, 2'b00);
    chk({tag, " done_end"}, {w_done_m, w_done_l}, 2'b11);
`ifdef SHIFT_REG_UNIV_PARITY_EN
    chk({tag, " parity"}, {w_par_m, w_par_l}, {2{^d}});
`endif
    r_mode = 3'b000;
  endtask

  initial begin
    rst_n   = 1'b0;
    r_mode  = 3'b000;
    r_di    = 8'hAF;
    r_si    = 1'b0;
    r_start = 1'b0;
    tick();
    tick();
    chk("rst do", {w_do_m, w_do_l}, 16'h0000);
    chk("rst busy", {w_busy_m, w_busy_l}, 2'b00);
    chk("rst done", {w_done_m, w_done_l}, 2'b00);
    chk("rst so", {w_so_m, w_so_l}, 2'b00);
`ifdef SHIFT_REG_UNIV_PARITY_EN
    chk("rst parity", {w_par_m, w_par_l}, 2'b00);
`endif

    rst_n  = 1'b1;
    r_mode = 3'b001;
    tick();
    chk("load", {w_do_m, w_do_l}, 16'hAFAF);
    r_mode = 3'b000;
    tick(); tick(); tick();
    chk("hold", {w_do_m, w_do_l}, 16'hAFAF);

    r_mode = 3'b010; r_si = 1'b1; tick();
    chk("shl", {w_do_m, w_do_l}, 16'h5F5F);
    r_mode = 3'b011; r_si = 1'b0; tick();
    chk("shr", {w_do_m, w_do_l}, 16'h2F2F);
    r_mode = 3'b100; tick();
    chk("rotl", {w_do_m, w_do_l}, 16'h5E5E);
    r_mode = 3'b101; tick();
    chk("rotr", {w_do_m, w_do_l}, 16'h2F2F);
    r_mode = 3'b110; tick();
    chk("rsvd110", {w_do_m, w_do_l}, 16'h2F2F);
    r_mode = 3'b111; tick();
    chk("rsvd111", {w_do_m, w_do_l}, 16'h2F2F);

    // start with ROTR asserted: start must win; si=1 fills the residue
    r_si = 1'b1;
    ser(8'hA5, 3, 3'b101, "ser_a5");
    chk("ser_a5 residue", {w_do_m, w_do_l}, 16'hFFFF);

    // accepted while done is high: back-to-back word
    r_si = 1'b0;
    ser(8'h01, 2, 3'b001, "ser_01");
    chk("ser_01 residue", {w_do_m, w_do_l}, 16'h8000);
    tick();
    chk("idle after 01", {w_busy_m, w_busy_l, w_done_m, w_done_l}, 4'b0000);

    // asynchronous reset in the 4th busy cycle
    r_di = 8'hA5; r_start = 1'b1; tick();
    r_start = 1'b0;
    tick(); tick(); tick();
    chk("pre-abort busy", {w_busy_m, w_busy_l}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("abort do", {w_do_m, w_do_l}, 16'h0000);
    chk("abort busy", {w_busy_m, w_busy_l}, 2'b00);
    chk("abort so", {w_so_m, w_so_l}, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-abort", {w_busy_m, w_busy_l, w_done_m, w_done_l}, 4'b0000);
    tick();
    chk("post-abort done", {w_done_m, w_done_l}, 2'b00);

    ser(8'h3C, -1, 3'b000, "ser_3c");
    tick();
    ser(8'h07, -1, 3'b000, "ser_07");
    chk("ser_07 residue", {w_do_m, w_do_l}, 16'h8000);
    tick();
    chk("final idle", {w_busy_m, w_busy_l, w_done_m, w_done_l}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
